// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Used by mc_ctrl_outdec and multicycle_control.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAddr = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StRExec   = 4'd6,
      StRWb     = 4'd7,
      StBranch  = 4'd8,
      StJump    = 4'd9,
      StAddiEx  = 4'd10,
      StAddiWb  = 4'd11,
      StTrap    = 4'd12
   } state_e;

   localparam logic [2:0] OpIllegal = 3'b000;
   localparam logic [2:0] OpR       = 3'b001;
   localparam logic [2:0] OpLw      = 3'b010;
   localparam logic [2:0] OpSw      = 3'b011;
   localparam logic [2:0] OpJ       = 3'b100;
   localparam logic [2:0] OpBeq     = 3'b101;
   localparam logic [2:0] OpBne     = 3'b110;
   localparam logic [2:0] OpAddi    = 3'b111;

   localparam logic [1:0] AluSrcBRegB  = 2'b00;
   localparam logic [1:0] AluSrcBFour  = 2'b01;
   localparam logic [1:0] AluSrcBImm   = 2'b10;
   localparam logic [1:0] AluSrcBImmSh = 2'b11;

   localparam logic [1:0] AluOpAdd   = 2'b00;
   localparam logic [1:0] AluOpSub   = 2'b01;
   localparam logic [1:0] AluOpFunct = 2'b10;

   localparam logic [1:0] PcSrcAlu    = 2'b00;
   localparam logic [1:0] PcSrcAluOut = 2'b01;
   localparam logic [1:0] PcSrcJump   = 2'b10;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       branch_ne;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       regdest;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsource;
      logic       instr_done;
   } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decoder: FSM state + mem_ready + latched opcode class -> control vector.
// With MC_CTRL_ILLEGAL_TRAP_EN undefined, class 000 retires from DECODE as a NOP.
module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  state_e     state_i,
   input  logic       mem_ready_i,
   input  logic [2:0] op_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      unique case (state_i)
         StFetch: begin
            ctrl_o.memread  = 1'b1;
            ctrl_o.alusrcb  = AluSrcBFour;
            ctrl_o.aluop    = AluOpAdd;
            ctrl_o.pcsource = PcSrcAlu;
            // PC and IR update only on the cycle the fetch completes
            ctrl_o.irwrite  = mem_ready_i;
            ctrl_o.pcwrite  = mem_ready_i;
         end
         StDecode: begin
            ctrl_o.alusrcb = AluSrcBImmSh;
            ctrl_o.aluop   = AluOpAdd;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
            ctrl_o.instr_done = (op_i == OpIllegal);
`endif
         end
         StMemAddr: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = AluSrcBImm;
            ctrl_o.aluop   = AluOpAdd;
         end
         StMemRd: begin
            ctrl_o.memread = 1'b1;
            ctrl_o.iord    = 1'b1;
         end
         StMemWb: begin
            ctrl_o.regwrite   = 1'b1;
            ctrl_o.memtoreg   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         StMemWr: begin
            ctrl_o.memwrite   = 1'b1;
            ctrl_o.iord       = 1'b1;
            ctrl_o.instr_done = mem_ready_i;
         end
         StRExec: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = AluSrcBRegB;
            ctrl_o.aluop   = AluOpFunct;
         end
         StRWb: begin
            ctrl_o.regwrite   = 1'b1;
            ctrl_o.regdest    = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         StBranch: begin
            ctrl_o.alusrca     = 1'b1;
            ctrl_o.alusrcb     = AluSrcBRegB;
            ctrl_o.aluop       = AluOpSub;
            ctrl_o.pcwritecond = 1'b1;
            ctrl_o.pcsource    = PcSrcAluOut;
            ctrl_o.branch_ne   = (op_i == OpBne);
            ctrl_o.instr_done  = 1'b1;
         end
         StJump: begin
            ctrl_o.pcwrite    = 1'b1;
            ctrl_o.pcsource   = PcSrcJump;
            ctrl_o.instr_done = 1'b1;
         end
         StAddiEx: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = AluSrcBImm;
            ctrl_o.aluop   = AluOpAdd;
         end
         StAddiWb: begin
            ctrl_o.regwrite   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, latched opcode class, retire counter.
// MC_CTRL_ILLEGAL_TRAP_EN: class 000 traps (sticky illegal) instead of retiring as a NOP.
module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W = 8,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] in,
   input  logic                mem_ready,
   output logic                pcwrite,
   output logic                pcwritecond,
   output logic                branch_ne,
   output logic                iord,
   output logic                memread,
   output logic                memwrite,
   output logic                irwrite,
   output logic                memtoreg,
   output logic                regwrite,
   output logic                regdest,
   output logic                alusrca,
   output logic [1:0]          alusrcb,
   output logic [1:0]          aluop,
   output logic [1:0]          pcsource,
   output logic                instr_done,
   output logic [CNT_W-1:0]    retired,
   output logic                illegal,
   output logic [3:0]          state
);

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            dec_ctrl;
   ctrl_t            out_ctrl;

   // Only the class bits matter; upper opcode bits are deliberately ignored.
   logic unused_in;
   assign unused_in = ^in;

   mc_ctrl_outdec u_outdec (
      .state_i     (state_q),
      .mem_ready_i (mem_ready),
      .op_i        (op_q),
      .ctrl_o      (dec_ctrl)
   );

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      unique case (state_q)
         StFetch: begin
            if (mem_ready) begin
               state_d = StDecode;
               op_d    = in[2:0];
            end
         end
         StDecode: begin
            unique case (op_q)
               OpR:         state_d = StRExec;
               OpLw, OpSw:  state_d = StMemAddr;
               OpBeq, OpBne: state_d = StBranch;
               OpJ:         state_d = StJump;
               OpAddi:      state_d = StAddiEx;
               default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                  state_d   = StTrap;
                  illegal_d = 1'b1;
`else
                  state_d   = StFetch;
`endif
               end
            endcase
         end
         StMemAddr: state_d = (op_q == OpSw) ? StMemWr : StMemRd;
         StMemRd:   if (mem_ready) state_d = StMemWb;
         StMemWr:   if (mem_ready) state_d = StFetch;
         StRExec:   state_d = StRWb;
         StAddiEx:  state_d = StAddiWb;
         StMemWb, StRWb, StBranch, StJump, StAddiWb: state_d = StFetch;
         StTrap:    state_d = StTrap;
         default:   state_d = StFetch;
      endcase
      if (dec_ctrl.instr_done) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
         op_q    <= OpIllegal;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   // Reset state is FETCH, whose controls are non-zero, so gate them while rst is high.
   assign out_ctrl = rst ? '0 : dec_ctrl;

   assign pcwrite     = out_ctrl.pcwrite;
   assign pcwritecond = out_ctrl.pcwritecond;
   assign branch_ne   = out_ctrl.branch_ne;
   assign iord        = out_ctrl.iord;
   assign memread     = out_ctrl.memread;
   assign memwrite    = out_ctrl.memwrite;
   assign irwrite     = out_ctrl.irwrite;
   assign memtoreg    = out_ctrl.memtoreg;
   assign regwrite    = out_ctrl.regwrite;
   assign regdest     = out_ctrl.regdest;
   assign alusrca     = out_ctrl.alusrca;
   assign alusrcb     = out_ctrl.alusrcb;
   assign aluop       = out_ctrl.aluop;
   assign pcsource    = out_ctrl.pcsource;
   assign instr_done  = out_ctrl.instr_done;
   assign retired     = cnt_q;
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (CNT_W=4 to exercise counter wrap).
// Follows MC_CTRL_ILLEGAL_TRAP_EN for the class-000 expectations.
module tb_multicycle_control;

   logic       clk;
   logic       rst;
   logic [7:0] in;
   logic       mem_ready;
   logic       pcwrite, pcwritecond, branch_ne, iord, memread, memwrite, irwrite;
   logic       memtoreg, regwrite, regdest, alusrca, instr_done, illegal;
   logic [1:0] alusrcb, aluop, pcsource;
   logic [3:0] retired;
   logic [3:0] state;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   logic [3:0]  exp_ret = 4'd0;

   multicycle_control #(
      .OPCODE_W (8),
      .CNT_W    (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in          (in),
      .mem_ready   (mem_ready),
      .pcwrite     (pcwrite),
      .pcwritecond (pcwritecond),
      .branch_ne   (branch_ne),
      .iord        (iord),
      .memread     (memread),
      .memwrite    (memwrite),
      .irwrite     (irwrite),
      .memtoreg    (memtoreg),
      .regwrite    (regwrite),
      .regdest     (regdest),
      .alusrca     (alusrca),
      .alusrcb     (alusrcb),
      .aluop       (aluop),
      .pcsource    (pcsource),
      .instr_done  (instr_done),
      .retired     (retired),
      .illegal     (illegal),
      .state       (state)
   );

   logic [17:0] ctrls;
   assign ctrls = {pcwrite, pcwritecond, branch_ne, iord, memread, memwrite, irwrite, memtoreg,
                   regwrite, regdest, alusrca, alusrcb, aluop, pcsource, instr_done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [17:0] cv(input logic pcw, input logic pcwc, input logic bne,
                                      input logic iord_v, input logic mr, input logic mw,
                                      input logic irw, input logic m2r, input logic rw,
                                      input logic rd, input logic asa, input logic [1:0] asb,
                                      input logic [1:0] aop, input logic [1:0] pcs,
                                      input logic done);
      return {pcw, pcwc, bne, iord_v, mr, mw, irw, m2r, rw, rd, asa, asb, aop, pcs, done};
   endfunction

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      adv();
      rst = 1'b0;
      exp_ret = 4'd0;
   endtask

   // One instruction, mem_ready=1 in FETCH then mr_rest; state per cycle, controls at
   // FETCH and at the retiring cycle, retire pulse only in the last cycle.
   task automatic run_instr(input string tag, input logic [7:0] op, input int n,
                            input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                            input logic [3:0] s3, input logic [3:0] s4, input logic mr_rest,
                            input logic [17:0] last_cv);
      logic [3:0] st [5];
      st[0] = s0; st[1] = s1; st[2] = s2; st[3] = s3; st[4] = s4;
      in = op;
      for (int i = 0; i < n; i++) begin
         mem_ready = (i == 0) ? 1'b1 : mr_rest;
         #1;
         check({tag, " state"}, 32'(state), 32'(st[i]));
         check({tag, " done"}, 32'(instr_done), 32'(i == n - 1));
         check({tag, " retired"}, 32'(retired), 32'(exp_ret));
         if (i == 0)
            check({tag, " fetch ctrl"}, 32'(ctrls),
                  32'(cv(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0)));
         if (i == n - 1) begin
            check({tag, " last ctrl"}, 32'(ctrls), 32'(last_cv));
            exp_ret = exp_ret + 4'd1;
         end
         @(posedge clk);
         #1;
      end
      #1;
      check({tag, " end state"}, 32'(state), 32'd0);
      check({tag, " end retired"}, 32'(retired), 32'(exp_ret));
   endtask

   int cycles;
   int mw_cycles;

   initial begin
      rst = 1'b1;
      in = 8'h00;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst state", 32'(state), 32'd0);
      check("rst ctrls", 32'(ctrls), 32'd0);
      check("rst retired", 32'(retired), 32'd0);
      check("rst illegal", 32'(illegal), 32'd0);
      rst = 1'b0;
      #1;
      check("post-rst fetch ctrl", 32'(ctrls),
            32'(cv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0)));
      adv();
      check("fetch wait state", 32'(state), 32'd0);

      run_instr("lw", 8'h02, 5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1,
                cv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 1));

      // lw stalled in MEMRD, then asynchronous reset mid-wait.
      in = 8'h02;
      mem_ready = 1'b1;
      adv();
      adv();
      adv();
      mem_ready = 1'b0;
      #1;
      check("memrd state", 32'(state), 32'd3);
      check("memrd ctrl", 32'(ctrls),
            32'(cv(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0)));
      adv();
      check("memrd hold", 32'(state), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("async rst state", 32'(state), 32'd0);
      check("async rst ctrls", 32'(ctrls), 32'd0);
      check("async rst retired", 32'(retired), 32'd0);
      adv();
      rst = 1'b0;
      exp_ret = 4'd0;
      #1;
      check("release memread", 32'(memread), 32'd1);
      check("release alusrcb", 32'(alusrcb), 32'd1);
      check("release retired", 32'(retired), 32'd0);
      adv();

      // sw with three stalled cycles in MEMWR.
      in = 8'h03;
      cycles = 0;
      mw_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         mem_ready = (i >= 3 && i < 6) ? 1'b0 : 1'b1;
         #1;
         cycles++;
         if (memwrite) mw_cycles++;
         if (i >= 3 && i < 6) begin
            check("sw wait state", 32'(state), 32'd5);
            check("sw wait ctrl", 32'(ctrls),
                  32'(cv(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0)));
         end
         if (instr_done) begin
            adv();
            break;
         end
         adv();
      end
      exp_ret = exp_ret + 4'd1;
      check("sw cycles", 32'(cycles), 32'd7);
      check("sw memwrite cycles", 32'(mw_cycles), 32'd4);
      #1;
      check("sw end state", 32'(state), 32'd0);
      check("sw retired", 32'(retired), 32'(exp_ret));

      run_instr("bne", 8'h06, 3, 4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 1'b1,
                cv(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1));
      run_instr("beq", 8'h05, 3, 4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 1'b1,
                cv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1));
      run_instr("rtype", 8'h01, 4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 1'b1,
                cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 1));
      // mem_ready low outside memory states must not matter.
      run_instr("addi", 8'hA7, 4, 4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 1'b0,
                cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 1));
      run_instr("j", 8'h04, 3, 4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 1'b0,
                cv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1));

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      in = 8'hF0;
      mem_ready = 1'b1;
      #1;
      check("trap fetch", 32'(state), 32'd0);
      adv();
      check("trap decode", 32'(state), 32'd1);
      check("trap decode done", 32'(instr_done), 32'd0);
      adv();
      for (int i = 0; i < 20; i++) begin
         mem_ready = i[0];
         #1;
         check("trap state", 32'(state), 32'd12);
         check("trap illegal", 32'(illegal), 32'd1);
         check("trap ctrls", 32'(ctrls), 32'd0);
         adv();
      end
      check("trap retired", 32'(retired), 32'(exp_ret));
      do_reset();
      #1;
      check("trap cleared", 32'(illegal), 32'd0);
      check("trap rst state", 32'(state), 32'd0);
`else
      run_instr("nop", 8'hF0, 2, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 1'b1,
                cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1));
      check("nop illegal", 32'(illegal), 32'd0);
`endif

      do_reset();
      for (int k = 0; k < 17; k++) begin
         run_instr("jwrap", 8'h04, 3, 4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 1'b1,
                   cv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1));
      end
      check("wrap retired", 32'(retired), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
